jpeg_marker_framer: RTL and testbench

Final output stage of the JPEG encoder, directly downstream of the bit-packing/byte-stuffing stage. It wraps each entropy-coded scan byte stream into a complete JFIF frame: SOI marker (FF D8), a software-programmed header (APP0/DQT/SOF0/DHT/SOS bytes held in an internal header RAM), the scan bytes passed through unchanged, and the EOI marker (FF D9). It reports the byte count of every completed frame.

---
 rtl/jpeg_marker_framer_if.sv | 12 +
 rtl/jpeg_marker_framer.sv | 189 ++++++++++++++++++
 tb/tb_jpeg_marker_framer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_marker_framer_if.sv
// Byte stream with valid/ready handshake plus first/last sideband, shared by the
// scan input and framed output of the JPEG marker framer.
interface jpeg_marker_framer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tuser;
  logic       tlast;
  logic       tready;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/jpeg_marker_framer.sv
// Wraps each scan byte stream in SOI + programmed header + scan + EOI, 1 byte/cycle.
// Scan pass-through latency 1 cycle; output register holds under m_axis stall, s_axis_tready drops.
module jpeg_marker_framer #(
  parameter int HDR_DEPTH = 1024,
  localparam int AW = $clog2(HDR_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_we,
  input  logic [AW-1:0]         hdr_addr,
  input  logic [7:0]            hdr_wdata,
  input  logic                  hdr_len_we,
  input  logic [AW:0]           hdr_len_in,
  output logic                  busy,
  jpeg_marker_framer_if.slave   s_axis,
  jpeg_marker_framer_if.master  m_axis,
  output logic                  frame_done,
  output logic [31:0]           frame_bytes
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SOI0 = 3'd1,
    SOI1 = 3'd2,
    HDR  = 3'd3,
    SCAN = 3'd4,
    EOI0 = 3'd5,
    EOI1 = 3'd6
  } state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(HDR_DEPTH);

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW:0]     hdr_len_q, hdr_len_d;
  logic [7:0]      m_dat_q, m_dat_d;
  logic            m_vld_q, m_vld_d;
  logic            m_usr_q, m_usr_d;
  logic            m_lst_q, m_lst_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     fbytes_q, fbytes_d;
  logic            done_q, done_d;
  logic [7:0]      hdr_ram_q [HDR_DEPTH];

  logic            adv;
  logic            m_hs;
  logic            hdr_last;
  logic            s_rdy;
  logic            unused_tuser;

  // Output register may take a new byte when empty or when its byte leaves this cycle.
  assign adv          = !m_vld_q || m_axis.tready;
  assign m_hs         = m_vld_q && m_axis.tready;
  assign hdr_last     = ({1'b0, idx_q} == (hdr_len_q - 1'b1));
  assign unused_tuser = s_axis.tuser;

  assign s_axis.tready = s_rdy;
  assign m_axis.tdata  = m_dat_q;
  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tuser  = m_usr_q;
  assign m_axis.tlast  = m_lst_q;
  assign frame_done    = done_q;
  assign frame_bytes   = fbytes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (adv) begin
      case (state_q)
        IDLE: if (s_axis.tvalid) state_d = SOI0;
        SOI0: state_d = SOI1;
        SOI1: begin
          state_d = (hdr_len_q != '0) ? HDR : SCAN;
          idx_d   = '0;
        end
        HDR: begin
          if (hdr_last) begin
            state_d = SCAN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        SCAN: if (s_axis.tvalid && s_axis.tlast) state_d = EOI0;
        EOI0: state_d = EOI1;
        EOI1: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    s_rdy   = 1'b0;
    m_dat_d = m_dat_q;
    m_vld_d = m_vld_q;
    m_usr_d = m_usr_q;
    m_lst_d = m_lst_q;
    if (adv) begin
      m_vld_d = 1'b1;
      m_usr_d = 1'b0;
      m_lst_d = 1'b0;
      case (state_q)
        IDLE: m_vld_d = 1'b0;
        SOI0: begin
          m_dat_d = 8'hFF;
          m_usr_d = 1'b1;
        end
        SOI1: m_dat_d = 8'hD8;
        HDR:  m_dat_d = hdr_ram_q[idx_q];
        SCAN: begin
          s_rdy = 1'b1;
          if (s_axis.tvalid) begin
            m_dat_d = s_axis.tdata;
          end else begin
            m_vld_d = 1'b0;
          end
        end
        EOI0: m_dat_d = 8'hFF;
        EOI1: begin
          m_dat_d = 8'hD9;
          m_lst_d = 1'b1;
        end
        default: m_vld_d = 1'b0;
      endcase
    end
  end

  // Byte counter restarts when SOI FF is loaded; the output register is empty then.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SOI0 && adv) begin
      cnt_d = '0;
    end else if (m_hs && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end

    done_d   = m_hs && m_lst_q;
    fbytes_d = fbytes_q;
    if (done_d) begin
      fbytes_d = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    end

    hdr_len_d = hdr_len_q;
    if (hdr_len_we && !busy) begin
      hdr_len_d = (hdr_len_in > DEPTH_L) ? DEPTH_L : hdr_len_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      hdr_len_q <= '0;
      m_dat_q   <= '0;
      m_vld_q   <= 1'b0;
      m_usr_q   <= 1'b0;
      m_lst_q   <= 1'b0;
      cnt_q     <= '0;
      fbytes_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      hdr_len_q <= hdr_len_d;
      m_dat_q   <= m_dat_d;
      m_vld_q   <= m_vld_d;
      m_usr_q   <= m_usr_d;
      m_lst_q   <= m_lst_d;
      cnt_q     <= cnt_d;
      fbytes_q  <= fbytes_d;
      done_q    <= done_d;
    end
  end

  // Header contents survive reset; software reloads them only when it wants to.
  always_ff @(posedge clk) begin
    if (hdr_we && !busy && ({1'b0, hdr_addr} < DEPTH_L)) begin
      hdr_ram_q[hdr_addr] <= hdr_wdata;
    end
  end

endmodule

// File: tb/tb_jpeg_marker_framer.sv
// Bench for jpeg_marker_framer: scoreboard of expected output bytes and frame counts,
// a vector table of frame shapes, and hand sequences for latency, stalls, busy writes and reset.
module tb_jpeg_marker_framer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hdr_we;
  logic [AW-1:0] hdr_addr;
  logic [7:0]    hdr_wdata;
  logic          hdr_len_we;
  logic [AW:0]   hdr_len_in;
  logic          busy;
  logic          frame_done;
  logic [31:0]   frame_bytes;

  jpeg_marker_framer_if s_if ();
  jpeg_marker_framer_if m_if ();

  jpeg_marker_framer #(.HDR_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hdr_we      (hdr_we),
    .hdr_addr    (hdr_addr),
    .hdr_wdata   (hdr_wdata),
    .hdr_len_we  (hdr_len_we),
    .hdr_len_in  (hdr_len_in),
    .busy        (busy),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .frame_done  (frame_done),
    .frame_bytes (frame_bytes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       usr;
    logic       lst;
    logic [7:0] dat;
  } exp_t;

  typedef struct {
    int         len_in;
    int         nscan;
    bit         rnd;
    logic [7:0] seed;
    int         exp_fb;
  } vec_t;

  exp_t       expq[$];
  int         fbq[$];
  logic [7:0] hdr_m [DEPTH];
  int         hlen_m;
  int         nvec, errs, cyc;
  bit         rnd_rdy;
  bit         lat_arm, cont_arm, gap_arm;
  int         t_start, c0, cd9, cont_len, done_due;
  bit         prev_stall;
  exp_t       prev_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    nvec++;
    errs++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("stall_hold", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}, {1'b1, prev_out});
        if (lat_arm && m_if.tvalid) begin
          chk("soi_latency", cyc - t_start, 2);
          lat_arm = 1'b0;
        end
        if (frame_done) begin
          if (fbq.size() == 0) begin
            fail_now("spurious_frame_done");
          end else begin
            chk("frame_bytes", frame_bytes, fbq.pop_front());
            chk("done_timing", cyc, done_due);
          end
        end
        if (m_if.tvalid && m_if.tready) begin
          if (expq.size() == 0) begin
            fail_now("extra_output_byte");
          end else begin
            e = expq.pop_front();
            chk("out_byte", {m_if.tuser, m_if.tlast, m_if.tdata}, e);
            if (e.usr) begin
              c0 = cyc;
              if (gap_arm && cd9 >= 0) begin
                chk("b2b_gap", cyc - cd9, 2);
                gap_arm = 1'b0;
              end
            end
            if (e.lst) begin
              done_due = cyc + 1;
              cd9      = cyc;
              if (cont_arm) begin
                chk("frame_cycles", cyc - c0 + 1, cont_len);
                cont_arm = 1'b0;
              end
            end
          end
        end
        prev_stall = m_if.tvalid && !m_if.tready;
        prev_out   = {m_if.tuser, m_if.tlast, m_if.tdata};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic hdr_write(input int a, input logic [7:0] d, input bit take);
    hdr_we    = 1'b1;
    hdr_addr  = a[AW-1:0];
    hdr_wdata = d;
    @(posedge clk); #1;
    hdr_we = 1'b0;
    if (take) hdr_m[a] = d;
  endtask

  task automatic set_len(input int l, input bit take);
    hdr_len_we = 1'b1;
    hdr_len_in = l[AW:0];
    @(posedge clk); #1;
    hdr_len_we = 1'b0;
    if (take) hlen_m = (l > DEPTH) ? DEPTH : l;
  endtask

  task automatic push_frame(input logic [7:0] sc[$], input int fb, input bit full);
    expq.push_back({1'b1, 1'b0, 8'hFF});
    expq.push_back({1'b0, 1'b0, 8'hD8});
    for (int i = 0; i < hlen_m; i++) expq.push_back({1'b0, 1'b0, hdr_m[i]});
    foreach (sc[i]) expq.push_back({1'b0, 1'b0, sc[i]});
    if (full) begin
      expq.push_back({1'b0, 1'b0, 8'hFF});
      expq.push_back({1'b0, 1'b1, 8'hD9});
      fbq.push_back(fb);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last, input logic first);
    bit got = 1'b0;
    if (rnd_rdy && $urandom_range(0, 3) == 0) begin
      s_if.tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_if.tdata  = b;
    s_if.tlast  = last;
    s_if.tuser  = first;
    s_if.tvalid = 1'b1;
    for (int n = 0; n < 2000 && !got; n++) begin
      @(negedge clk);
      got = s_if.tready;
    end
    if (!got) fail_now("scan_accept");
    @(posedge clk); #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;
  endtask

  task automatic send_scan(input logic [7:0] sc[$], input bit with_last);
    foreach (sc[i]) send(sc[i], with_last && (i == sc.size() - 1), i == 0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      ok = (expq.size() == 0) && (fbq.size() == 0) && !busy;
    end
    if (!ok) begin
      fail_now("frame_complete");
      expq.delete();
      fbq.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t       vecs[6];
    logic [7:0] sc[$];
    logic [7:0] sc2[$];
    logic [7:0] init3[3];
    bit         seen_busy;

    vecs[0] = '{len_in: 4,  nscan: 10,  rnd: 1'b0, seed: 8'h10, exp_fb: 18};
    vecs[1] = '{len_in: 16, nscan: 3,   rnd: 1'b0, seed: 8'h80, exp_fb: 23};
    vecs[2] = '{len_in: 20, nscan: 2,   rnd: 1'b0, seed: 8'hC3, exp_fb: 22};
    vecs[3] = '{len_in: 1,  nscan: 200, rnd: 1'b1, seed: 8'h05, exp_fb: 205};
    vecs[4] = '{len_in: 0,  nscan: 30,  rnd: 1'b1, seed: 8'hF0, exp_fb: 34};
    vecs[5] = '{len_in: 7,  nscan: 1,   rnd: 1'b1, seed: 8'h77, exp_fb: 12};
    init3   = '{8'hE0, 8'h11, 8'h22};

    nvec = 0; errs = 0; hlen_m = 0; rnd_rdy = 1'b0;
    lat_arm = 1'b0; cont_arm = 1'b0; gap_arm = 1'b0; cd9 = -1; done_due = -1;
    rst_n = 1'b0;
    hdr_we = 1'b0; hdr_addr = '0; hdr_wdata = '0; hdr_len_we = 1'b0; hdr_len_in = '0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata, s_if.tready, busy, frame_done}, 0);
    chk("reset_frame_bytes", frame_bytes, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) hdr_write(i, (i < 3) ? init3[i] : 8'(8'h30 + i), 1'b1);

    // Reference frame: latency from idle and contiguous 12-cycle frame
    set_len(3, 1'b1);
    sc = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56};
    push_frame(sc, 12, 1'b1);
    cont_arm = 1'b1; cont_len = 12;
    lat_arm = 1'b1; t_start = cyc;
    send_scan(sc, 1'b1);
    wait_idle();
    chk("latency_seen", {lat_arm, cont_arm}, 0);

    set_len(0, 1'b1);
    sc = '{8'hAB};
    push_frame(sc, 5, 1'b1);
    send_scan(sc, 1'b1);
    wait_idle();

    for (int v = 0; v < 6; v++) begin
      rnd_rdy = 1'b0;
      set_len(vecs[v].len_in, 1'b1);
      sc.delete();
      for (int i = 0; i < vecs[v].nscan; i++) sc.push_back(vecs[v].seed + 8'(i * 7));
      push_frame(sc, vecs[v].exp_fb, 1'b1);
      rnd_rdy = vecs[v].rnd;
      send_scan(sc, 1'b1);
      wait_idle();
      rnd_rdy = 1'b0;
    end

    // Header writes while busy must not disturb this or the next frame
    set_len(2, 1'b1);
    sc = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    push_frame(sc, 12, 1'b1);
    fork
      send_scan(sc, 1'b1);
      begin
        seen_busy = 1'b0;
        for (int n = 0; n < 50 && !seen_busy; n++) begin
          @(negedge clk);
          seen_busy = busy;
        end
        if (!seen_busy) fail_now("busy_rise");
        @(posedge clk); #1;
        hdr_write(0, 8'h55, 1'b0);
        set_len(9, 1'b0);
      end
    join
    wait_idle();
    sc2 = '{8'hA1, 8'hA2, 8'hA3};
    push_frame(sc2, 9, 1'b1);
    send_scan(sc2, 1'b1);
    wait_idle();

    // Back-to-back frames: exactly one bubble between D9 and the next FF
    set_len(1, 1'b1);
    sc  = '{8'h11, 8'h22, 8'h33};
    sc2 = '{8'h44, 8'h55};
    push_frame(sc, 8, 1'b1);
    push_frame(sc2, 7, 1'b1);
    cd9 = -1; gap_arm = 1'b1;
    send_scan(sc, 1'b1);
    send_scan(sc2, 1'b1);
    wait_idle();
    chk("b2b_seen", gap_arm, 0);

    // Reset in the middle of the scan phase
    set_len(2, 1'b1);
    sc.delete();
    for (int i = 0; i < 10; i++) sc.push_back(8'(8'h60 + i));
    push_frame(sc, 0, 1'b0);
    send_scan(sc, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata, s_if.tready, busy, frame_done}, 0);
    chk("midrst_frame_bytes", frame_bytes, 0);
    expq.delete();
    hlen_m = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sc = '{8'h5A, 8'h6B};
    push_frame(sc, 6, 1'b1);
    send_scan(sc, 1'b1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
